// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - state_t and the four FSM state constants (SCAN, DEBOUNCE, PRESSED, RELEASE)
//   - ROW_IDLE and the active-low row-drive pattern for each row index
//   - helpers that map a row index to its drive pattern and pick the
//     lowest-numbered active (low) column from a synchronized column vector
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_SCAN     = 2'd0;
  localparam state_t ST_DEBOUNCE = 2'd1;
  localparam state_t ST_PRESSED  = 2'd2;
  localparam state_t ST_RELEASE  = 2'd3;

  localparam logic [3:0] ROW_IDLE  = 4'b1111;
  localparam logic [3:0] ROW_DRV_0 = 4'b1110;
  localparam logic [3:0] ROW_DRV_1 = 4'b1101;
  localparam logic [3:0] ROW_DRV_2 = 4'b1011;
  localparam logic [3:0] ROW_DRV_3 = 4'b0111;

  // Active-low one-hot row drive for a given row index (index 0 is row[1]).
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [3:0] drv;
    drv = ROW_IDLE;
    case (idx)
      2'd0: drv = ROW_DRV_0;
      2'd1: drv = ROW_DRV_1;
      2'd2: drv = ROW_DRV_2;
      2'd3: drv = ROW_DRV_3;
      default: drv = ROW_IDLE;
    endcase
    return drv;
  endfunction

  // Lowest column index whose sense line is low; ties between several
  // pressed keys in one row resolve to the smallest index.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] col_s);
    logic [1:0] idx;
    if (!col_s[0])      idx = 2'd0;
    else if (!col_s[1]) idx = 2'd1;
    else if (!col_s[2]) idx = 2'd2;
    else                idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen
// Free-running divider that produces a one-clock-wide enable pulse every
// SCAN_DIV clocks. It is used as a clock enable; no clock is derived.
// Parameters:
//   SCAN_DIV : clocks per tick period
// Ports:
//   clk   : input  clock, rising edge
//   rst_n : input  asynchronous active-low reset
//   tick  : output one-clock pulse, high on the last clock of each period
module scan_tick_gen #(
  parameter int SCAN_DIV = 5000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(SCAN_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..SCAN_DIV-1 and wrap; the tick marks the wrap clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, debounces press and release, and
// presents one accepted key at a time through a valid/ack handshake.
// Build option:
//   KEYPAD_ACCUM_EN : when defined, every accepted handshake shifts key_code
//                     into a 4-digit hex accumulator driven on value; when
//                     undefined, value is tied to zero and no flops are built.
// Parameters:
//   SCAN_DIV     : clocks per row dwell (scan tick period)
//   DEBOUNCE_CNT : consecutive ticks needed to accept a press or a release
// Ports:
//   clk       : input  clock, rising edge
//   rst_n     : input  asynchronous active-low reset
//   row[4:1]  : output row drive, active-low, one-hot-low
//   col[4:1]  : input  column sense, active-low, asynchronous to clk
//   key_code  : output accepted key {row_idx, col_idx}
//   key_valid : output key_code holds an accepted key
//   key_ack   : input  consumer takes key_code
//   value     : output accumulated hex entry (zero when accumulator disabled)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:1]  row,
  input  logic [4:1]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic [15:0] value
);

  localparam int DW = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT - 1);

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  state_t        r_state;
  logic [1:0]    r_row_idx;
  logic [1:0]    r_col_idx;
  logic [DW-1:0] r_db_cnt;
  logic [3:0]    r_key_code;
  logic          r_key_valid;

  logic          w_tick;
  logic [3:0]    w_col_s;
  logic          w_any_low;
  logic          w_all_high;
  logic          w_cap_low;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  // Two-flop synchronizer on the column lines; idles high like the pull-ups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= col;
      r_sync2 <= r_sync1;
    end
  end

  assign w_col_s    = r_sync2;
  assign w_any_low  = (w_col_s != 4'b1111);
  assign w_all_high = (w_col_s == 4'b1111);
  assign w_cap_low  = ~w_col_s[r_col_idx];

  // Scan/debounce FSM. The row index only moves on ticks in SCAN, or when
  // leaving DEBOUNCE/RELEASE back to SCAN, so the row stays frozen on the
  // captured key for the whole press/release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SCAN;
      r_row_idx   <= 2'd0;
      r_col_idx   <= 2'd0;
      r_db_cnt    <= '0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_SCAN: begin
          if (w_tick) begin
            if (w_any_low) begin
              r_col_idx <= lowest_low_col(w_col_s);
              r_db_cnt  <= '0;
              r_state   <= ST_DEBOUNCE;
            end else begin
              r_row_idx <= r_row_idx + 2'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (w_tick) begin
            if (w_cap_low) begin
              if (r_db_cnt == DB_LAST) begin
                r_key_code  <= {r_row_idx, r_col_idx};
                r_key_valid <= 1'b1;
                r_db_cnt    <= '0;
                r_state     <= ST_PRESSED;
              end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
              end
            end else begin
              r_db_cnt  <= '0;
              r_row_idx <= r_row_idx + 2'd1;
              r_state   <= ST_SCAN;
            end
          end
        end
        ST_PRESSED: begin
          // Column activity is ignored here; only the consumer ends it.
          if (key_ack) begin
            r_key_valid <= 1'b0;
            r_db_cnt    <= '0;
            r_state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_tick) begin
            if (w_all_high) begin
              if (r_db_cnt == DB_LAST) begin
                r_db_cnt  <= '0;
                r_row_idx <= r_row_idx + 2'd1;
                r_state   <= ST_SCAN;
              end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
              end
            end else begin
              r_db_cnt <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_SCAN;
        end
      endcase
    end
  end

  assign row       = row_drive(r_row_idx);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;

`ifdef KEYPAD_ACCUM_EN
  logic [15:0] r_value;

  // Shift each handshaken key in as the least significant hex digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 16'h0000;
    end else if (r_key_valid && key_ack) begin
      r_value <= {r_value[11:0], r_key_code};
    end
  end

  assign value = r_value;
`else
  assign value = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
// A behavioural keypad pulls col lines low for pressed keys on the driven
// row. Expected key codes are queued when a press is applied and popped by
// a monitor when key_valid rises. Honours KEYPAD_ACCUM_EN for value.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [4:1]  row;
  logic [4:1]  col;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyAck;
  logic [15:0] value;

  logic [15:0] keyMask;
  logic [15:0] expVal;
  logic [3:0]  expQ[$];
  logic        prevValid;
  int          checkCount = 0;
  int          errorCount = 0;
  int          edgeCnt = 0;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (keyCode),
    .key_valid (keyValid),
    .key_ack   (keyAck),
    .value     (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Keypad model: key (r,c) is mask bit r*4+c and shorts row r+1 to col c+1.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r+1] && keyMask[r*4+c]) col[c+1] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Scoreboard pop on each rising key_valid.
  initial prevValid = 1'b0;
  always @(negedge clk) begin
    if (keyValid && !prevValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedKey", 16'(keyCode), 16'hFFFF);
      end else begin
        logic [3:0] e;
        e = expQ.pop_front();
        checkOutput("keyCode", 16'(keyCode), 16'(e));
      end
    end
    prevValid = keyValid;
  end

  // Wait (bounded) for row to newly become target; returns the edge index.
  task automatic waitRowTo(input logic [3:0] target, output int edgeAt);
    int n;
    n = 0;
    while (row == target && n < 100) begin @(negedge clk); n++; end
    while (row != target && n < 100) begin @(negedge clk); n++; end
    checkOutput("rowReach", 16'(row), 16'(target));
    edgeAt = edgeCnt;
  endtask

  // Press a key pattern, expect the given code, release, ack, check value.
  task automatic applyStimulus(input logic [15:0] mask, input logic [3:0] code);
    int n;
    expQ.push_back(code);
    keyMask = mask;
    n = 0;
    while (!keyValid && n < 150) begin @(negedge clk); n++; end
    checkOutput("validSeen", 16'(keyValid), 16'h0001);
    keyMask = 16'h0000;
    repeat (4) @(negedge clk);
    keyAck = 1'b1;
    @(negedge clk);
    checkOutput("validDrop", 16'(keyValid), 16'h0000);
    keyAck = 1'b0;
`ifdef KEYPAD_ACCUM_EN
    expVal = {expVal[11:0], code};
`endif
    repeat (20) @(negedge clk);
    checkOutput("value", value, expVal);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] rowSeq [4];
    int relEdge, prevEdge, e, rowEdge, ackEdge, d, t1, held, stale;

    rowSeq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst_n   = 1'b0;
    keyAck  = 1'b0;
    keyMask = 16'h0000;
    expVal  = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("rstRow", 16'(row), 16'h000E);
    checkOutput("rstValid", 16'(keyValid), 16'h0000);
    checkOutput("rstCode", 16'(keyCode), 16'h0000);
    checkOutput("rstValue", value, 16'h0000);
    rst_n = 1'b1;
    relEdge = edgeCnt;

    // Idle scan: rows rotate every 4 clocks.
    prevEdge = relEdge;
    for (int i = 0; i < 4; i++) begin
      waitRowTo(rowSeq[i], e);
      checkOutput("rowPeriod", 16'(e - prevEdge), 16'd4);
      prevEdge = e;
    end
    checkOutput("idleValid", 16'(keyValid), 16'h0000);

    // Key 6 (row[2], col[3]): valid 16 clocks after row[2] is driven.
    waitRowTo(4'b1101, rowEdge);
    expQ.push_back(4'h6);
    keyMask = 16'h0040;
    e = 0;
    while (!keyValid && e < 40) begin @(negedge clk); e++; end
    checkOutput("pressLatency", 16'(edgeCnt - rowEdge), 16'd16);
    checkOutput("rowFrozen", 16'(row), 16'h000D);

    // Hold ack off for 50 clocks, releasing the key partway through.
    held = 1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) keyMask = 16'h0000;
      @(negedge clk);
      if (!keyValid || keyCode != 4'h6) held = 0;
    end
    checkOutput("heldValid", 16'(held), 16'h0001);
    ackEdge = edgeCnt + 1;
    keyAck = 1'b1;
    @(negedge clk);
    keyAck = 1'b0;
    checkOutput("ackDrop", 16'(keyValid), 16'h0000);
`ifdef KEYPAD_ACCUM_EN
    expVal = {expVal[11:0], 4'h6};
`endif
    d = ((rowEdge - ackEdge) % 4 + 4) % 4;
    if (d == 0) d = 4;
    t1 = ackEdge + d;
    waitRowTo(4'b1011, e);
    checkOutput("resumeEdge", 16'(e - t1), 16'd8);
    checkOutput("valueAfter6", value, expVal);

    // Short press on key 4 aborts debounce; scan moves on to row[3].
    waitRowTo(4'b1101, rowEdge);
    keyMask = 16'h0010;
    repeat (5) @(negedge clk);
    keyMask = 16'h0000;
    waitRowTo(4'b1011, e);
    checkOutput("abortResume", 16'(e - rowEdge), 16'd8);
    checkOutput("abortValid", 16'(keyValid), 16'h0000);

    // Ack without a pending key is ignored.
    keyAck = 1'b1;
    repeat (8) @(negedge clk);
    keyAck = 1'b0;
    checkOutput("strayAckValue", value, expVal);
    checkOutput("strayAckValid", 16'(keyValid), 16'h0000);

    // Keys 1,2,3,4; key 1 pressed together with key 3 (lowest column wins).
    applyStimulus(16'h000A, 4'h1);
    applyStimulus(16'h0004, 4'h2);
    applyStimulus(16'h0008, 4'h3);
    applyStimulus(16'h0010, 4'h4);
`ifdef KEYPAD_ACCUM_EN
    checkOutput("value1234", value, 16'h1234);
`else
    checkOutput("valueZero", value, 16'h0000);
`endif

    // Reset in the middle of debouncing key 7.
    waitRowTo(4'b1101, rowEdge);
    keyMask = 16'h0080;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstRow", 16'(row), 16'h000E);
    checkOutput("midRstValid", 16'(keyValid), 16'h0000);
    checkOutput("midRstCode", 16'(keyCode), 16'h0000);
    checkOutput("midRstValue", value, 16'h0000);
    expVal = 16'h0000;
    keyMask = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstRow", 16'(row), 16'h000E);
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (keyValid) stale = 1;
    end
    checkOutput("noStaleKey", 16'(stale), 16'h0000);
    checkOutput("queueEmpty", 16'(expQ.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
